mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the instruction-fetch port and the data port of the 32-bit MIPS pipeline. The data port is driven by the decoder's MemRead/MemWrite for LW/SW. The block runs a grant/busy/done state machine, holds the memory interface stable for the programmed latency and returns registered read data with a one-cycle ready pulse. It raises per-port stall flags that the pipeline control uses to freeze IF or MEM.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between instruction fetch and data access.
// Runs an IDLE/BUSY/DONE sequence per access, returns registered read data and a one-cycle ready pulse.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t     state;
    logic       gnt;        // 0 = fetch, 1 = data
    logic       last_gnt;
    logic [3:0] cnt;
    logic       we;

    logic d_req;
    logic pick_d;

    assign d_req  = d_read | d_write;
    // Data wins a tie unless it was served last, so sustained contention alternates.
    assign pick_d = d_req & (~if_req | ~last_gnt);

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b0;
            cnt       <= 4'd0;
            we        <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        gnt       <= pick_d;
                        last_gnt  <= pick_d;
                        cnt       <= 4'd0;
                        we        <= pick_d & d_write;
                        mem_we    <= pick_d & d_write;
                        mem_addr  <= pick_d ? d_addr : if_addr;
                        // Fetches never write, so the store port is the only wdata source.
                        mem_wdata <= d_wdata;
                        mem_en    <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        if (!we) begin
                            if (gnt) d_rdata  <= mem_rdata;
                            else     if_rdata <= mem_rdata;
                        end
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        if_ready <= ~gnt;
                        d_ready  <= gnt;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: timeline reference model, directed literal scenarios,
// randomized requester traffic, and a WAIT_CYCLES=0 back-to-back fetch instance.
module tb_mem_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        if_req0 = 1'b0;
    logic [31:0] if_addr0 = 32'd0;
    logic [31:0] if_rdata0;
    logic        if_ready0;
    logic [31:0] d_rdata0;
    logic        d_ready0;
    logic        stall_if0;
    logic        stall_mem0;
    logic        mem_en0;
    logic        mem_we0;
    logic [31:0] mem_addr0;
    logic [31:0] mem_wdata0;
    logic [31:0] mem_rdata0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
        .d_read(1'b0), .d_write(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
        .d_rdata(d_rdata0), .d_ready(d_ready0),
        .stall_if(stall_if0), .stall_mem(stall_mem0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h100) return 32'h20020005;
        return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    // Memory: data is only correct in the last cycle of an enable run; earlier cycles return junk.
    logic [3:0] en_cnt, en_cnt0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt  <= 4'd0;
            en_cnt0 <= 4'd0;
        end else begin
            en_cnt  <= mem_en  ? en_cnt + 4'd1  : 4'd0;
            en_cnt0 <= mem_en0 ? en_cnt0 + 4'd1 : 4'd0;
        end
    end
    assign mem_rdata  = (mem_en  && en_cnt == 4'(W)) ? mem_f(mem_addr)  : {28'hBAD0000, en_cnt};
    assign mem_rdata0 = (mem_en0 && en_cnt0 == 4'd0) ? mem_f(mem_addr0) : {28'hBAD0000, en_cnt0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each access is a timeline of age 1..W+1 (memory busy) then age W+2 (ready).
    int          m_age;
    bit          m_gnt_d, m_last_d, m_we;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = 0; m_gnt_d = 0; m_last_d = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0;
        end else if (m_age == 0) begin
            if ((d_read || d_write) && (!if_req || !m_last_d)) begin
                m_gnt_d = 1; m_we = d_write; m_addr = d_addr; m_wdata = d_wdata; m_age = 1;
            end else if (if_req) begin
                m_gnt_d = 0; m_we = 0; m_addr = if_addr; m_wdata = d_wdata; m_age = 1;
            end
            if (m_age == 1) m_last_d = m_gnt_d;
        end else if (m_age == W + 2) begin
            m_age = 0;
        end else begin
            if (m_age == W + 1 && !m_we) begin
                if (m_gnt_d) m_d_rdata = mem_f(m_addr);
                else         m_if_rdata = mem_f(m_addr);
            end
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit e_en, e_ifr, e_dr;
            e_en  = (m_age >= 1 && m_age <= W + 1);
            e_ifr = (m_age == W + 2) && !m_gnt_d;
            e_dr  = (m_age == W + 2) && m_gnt_d;
            check("m_mem_en", 32'(mem_en), 32'(e_en));
            check("m_mem_we", 32'(mem_we), 32'(e_en && m_we));
            check("m_mem_addr", mem_addr, m_addr);
            check("m_mem_wdata", mem_wdata, m_wdata);
            check("m_if_ready", 32'(if_ready), 32'(e_ifr));
            check("m_d_ready", 32'(d_ready), 32'(e_dr));
            check("m_if_rdata", if_rdata, m_if_rdata);
            check("m_d_rdata", d_rdata, m_d_rdata);
            check("m_stall_if", 32'(stall_if), 32'(if_req && !e_ifr));
            check("m_stall_mem", 32'(stall_mem), 32'((d_read || d_write) && !e_dr));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        if_req = 0; d_read = 0; d_write = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        if_req = 0; d_read = 0; d_write = 0;
        repeat (n) next_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pulses, last_k, cnt_we;
        bit upd;
        logic [2:0] op;

        // Reset values
        #1;
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ready", 32'(if_ready), 0);
        check("rst_d_ready", 32'(d_ready), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        apply_reset();

        // Single fetch
        next_cycle();
        if_req = 1; if_addr = 32'h100;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t1_mem_en", 32'(mem_en), 32'(k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) check("t1_mem_addr", mem_addr, 32'h100);
            check("t1_if_ready", 32'(if_ready), 32'(k == 4));
            if (k <= 3) check("t1_stall_if", 32'(stall_if), 1);
            if (k == 4) check("t1_if_rdata", if_rdata, 32'h20020005);
            next_cycle();
            if (k == 3) if_req = 0;
        end

        // Contention after reset: D, I, D, I
        apply_reset();
        next_cycle();
        if_req = 1; if_addr = 32'h180; d_read = 1; d_addr = 32'h40;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t2_d_ready", 32'(d_ready), 32'(k == 4 || k == 14));
            check("t2_if_ready", 32'(if_ready), 32'(k == 9 || k == 19));
            if ((k >= 1 && k <= 3) || (k >= 11 && k <= 13)) check("t2_addr_d", mem_addr, 32'h40);
            if ((k >= 6 && k <= 8) || (k >= 16 && k <= 18)) check("t2_addr_if", mem_addr, 32'h180);
            if (k == 4) check("t2_d_rdata", d_rdata, mem_f(32'h40));
            if (k == 9) check("t2_if_rdata", if_rdata, mem_f(32'h180));
            if (k < 19) next_cycle();
        end
        idle_cycles(5);

        // Store
        d_write = 1; d_addr = 32'h44; d_wdata = 32'hDEADBEEF;
        cnt_we = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_we && mem_wdata == 32'hDEADBEEF) cnt_we++;
            check("t3_d_ready", 32'(d_ready), 32'(k == 4));
            if (k == 4) check("t3_d_rdata_hold", d_rdata, mem_f(32'h40));
            next_cycle();
            if (k == 3) d_write = 0;
        end
        check("t3_we_cycles", 32'(cnt_we), 32'(W + 1));

        // Read and write both high acts as a write
        d_read = 1; d_write = 1; d_addr = 32'h48; d_wdata = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) check("t4_mem_we", 32'(mem_we), 1);
            if (k == 4) check("t4_d_ready", 32'(d_ready), 1);
            if (k == 4) check("t4_d_rdata_hold", d_rdata, mem_f(32'h40));
            next_cycle();
            if (k == 3) begin d_read = 0; d_write = 0; end
        end
        idle_cycles(2);

        // Reset during the second BUSY cycle
        if_req = 1; if_addr = 32'h300;
        next_cycle();
        next_cycle();
        #1 rst_n = 0; if_req = 0;
        #1;
        check("t5_mem_en", 32'(mem_en), 0);
        check("t5_mem_addr", mem_addr, 0);
        check("t5_if_ready", 32'(if_ready), 0);
        check("t5_if_rdata", if_rdata, 0);
        check("t5_d_rdata", d_rdata, 0);
        @(posedge clk);
        #2 rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_no_ready", 32'(if_ready | d_ready), 0);
        end
        next_cycle();
        if_req = 1; if_addr = 32'h200;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_post_en", 32'(mem_en), 32'(k >= 1 && k <= 3));
            check("t5_post_ready", 32'(if_ready), 32'(k == 4));
            if (k == 4) check("t5_post_rdata", if_rdata, mem_f(32'h200));
            next_cycle();
            if (k == 3) if_req = 0;
        end
        idle_cycles(3);

        // Randomized traffic following the requester rules
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            if (!if_req || if_ready) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(d_read || d_write) || d_ready) begin
                op      = 3'($urandom_range(0, 4));
                d_read  = (op == 3'd1 || op == 3'd3);
                d_write = (op == 3'd2 || op == 3'd3);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
        end
        idle_cycles(W + 6);

        // WAIT_CYCLES = 0: back-to-back fetches every 3 cycles
        if_req0 = 1; if_addr0 = 32'h1000;
        pulses = 0; last_k = -1; upd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("w0_mem_en", 32'(mem_en0), 32'(k % 3 == 1));
            check("w0_if_ready", 32'(if_ready0), 32'(k % 3 == 2));
            if (if_ready0) begin
                check("w0_if_rdata", if_rdata0, mem_f(if_addr0));
                if (last_k >= 0) check("w0_interval", 32'(k - last_k), 3);
                last_k = k;
                pulses++;
                upd = 1;
            end
            next_cycle();
            if (upd) if_addr0 += 32'd4;
            upd = 0;
        end
        if_req0 = 0;
        check("w0_pulses", 32'(pulses), 10);
        repeat (4) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
